// File: rtl/sar_pkg.sv
// sar_pkg
// Shared types and limits for the successive-approximation search controller.
//   sar_state_t     : controller state encoding (IDLE, TEST, WAIT, DONE)
//   SAR_MAX_CMP_LAT : largest supported comparator latency, in wait cycles per bit
//   sar_wcnt_width  : width of the per-bit wait counter for a given latency
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } sar_state_t;

    localparam int SAR_MAX_CMP_LAT = 3;

    // ceil(log2(lat+1)), never narrower than one bit so the counter always exists.
    function automatic int sar_wcnt_width(input int lat);
        int w;
        w = $clog2(lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sar_search.sv
// sar_search
// Successive-approximation controller. Steers the B operand of an external
// magnitude comparator (A = unknown target) and rebuilds the target MSB first
// from the comparator's single "target < trial" flag, one bit per slot.
//
// Parameters
//   WIDTH   : width of target, trial word and result
//   CMP_LAT : extra wait cycles per bit before lt_in is trusted (0..3)
// Ports
//   clk     in  : clock, rising edge
//   rst_n   in  : asynchronous active-low reset, released synchronously
//   start   in  : search request, only honoured in IDLE
//   lt_in   in  : comparator flag, 1 when target < trial; used in TEST only
//   trial   out : registered candidate driven to the comparator B input
//   busy    out : search in progress (TEST/WAIT)
//   done    out : one-cycle pulse, result valid
//   result  out : registered final value, held until the next search ends
//
// state | meaning
// IDLE  | waiting for start; result holds the last answer
// WAIT  | trial is stable, letting a registered comparator settle
// TEST  | lt_in sampled on this edge; current bit resolved, next bit tried
// DONE  | result valid, done pulsed for this single cycle
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CMP_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             lt_in,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int WCW = sar_wcnt_width(CMP_LAT);
    localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [IW-1:0]  IDX_TOP  = IW'(WIDTH - 1);
    localparam logic [WCW-1:0] WCNT_END = WCW'(CMP_LAT - 1);

    generate
        if (CMP_LAT < 0 || CMP_LAT > SAR_MAX_CMP_LAT) begin : g_bad_lat
            $error("sar_search: CMP_LAT out of supported range");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("sar_search: WIDTH must be at least 1");
        end
    endgenerate

    sar_state_t       state, state_n;
    logic [WIDTH-1:0] trial_n;
    logic [WIDTH-1:0] result_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WCW-1:0]   wcnt, wcnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            trial  <= '0;
            result <= '0;
            idx    <= IDX_TOP;
            wcnt   <= '0;
        end else begin
            state  <= state_n;
            trial  <= trial_n;
            result <= result_n;
            idx    <= idx_n;
            wcnt   <= wcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        trial_n  = trial;
        result_n = result;
        idx_n    = idx;
        wcnt_n   = wcnt;

        unique case (state)
            IDLE: begin
                if (start) begin
                    trial_n            = '0;
                    trial_n[WIDTH-1]   = 1'b1;
                    idx_n              = IDX_TOP;
                    wcnt_n             = '0;
                    if (CMP_LAT == 0) begin
                        state_n = TEST;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end

            WAIT: begin
                wcnt_n = wcnt + 1'b1;
                if (wcnt == WCNT_END) begin
                    state_n = TEST;
                end
            end

            TEST: begin
                // Target below trial means the bit under test overshoots.
                if (lt_in) begin
                    trial_n[idx] = 1'b0;
                end
                if (idx != '0) begin
                    trial_n[idx - 1'b1] = 1'b1;
                    idx_n               = idx - 1'b1;
                    wcnt_n              = '0;
                    if (CMP_LAT == 0) begin
                        state_n = TEST;
                    end else begin
                        state_n = WAIT;
                    end
                end else begin
                    // Last bit resolved: trial_n already holds the answer.
                    result_n = trial_n;
                    state_n  = DONE;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Decoded straight from the state register, so both are glitch-free and
    // busy drops in exactly the cycle done rises.
    assign busy = (state == TEST) || (state == WAIT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search
// Directed bench for sar_search. Two instances share clock and reset:
// u_lat0 (WIDTH=4, CMP_LAT=0) with an ideal comparator, and u_lat2
// (WIDTH=4, CMP_LAT=2) whose comparator answer is inverted whenever the
// controller is not in a TEST slot, so any sampling outside TEST corrupts
// the result. Inputs change 1 time unit after the rising edge; outputs are
// sampled at the same point, before any new input takes effect.
module tb_sar_search;

    logic       clk;
    logic       rst_n;
    logic       start0, start2;
    logic       lt0, lt2;
    logic [3:0] tgt0, tgt2;
    logic [3:0] trial0, trial2;
    logic [3:0] result0, result2;
    logic       busy0, busy2;
    logic       done0, done2;
    logic       garble;

    int total;
    int bad;

    sar_search #(.WIDTH(4), .CMP_LAT(0)) u_lat0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start0),
        .lt_in  (lt0),
        .trial  (trial0),
        .busy   (busy0),
        .done   (done0),
        .result (result0)
    );

    sar_search #(.WIDTH(4), .CMP_LAT(2)) u_lat2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
        .lt_in  (lt2),
        .trial  (trial2),
        .busy   (busy2),
        .done   (done2),
        .result (result2)
    );

    // Behavioural comparators: A = target, B = trial.
    assign lt0 = (tgt0 < trial0);
    assign lt2 = garble ^ (tgt2 < trial2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One search on the CMP_LAT=0 instance. Returns the trial words seen in
    // the TEST cycles (packed MSB-first), the edge count from start to done,
    // whether done was a single-cycle pulse, and whether the previous result
    // stayed put until done. Leaves the bench in the cycle after done.
    task automatic search0(input logic [3:0] t, output logic [15:0] seq,
                           output int ncyc, output bit done_one, output bit res_held);
        logic [3:0] prev;
        prev     = result0;
        seq      = '0;
        ncyc     = -1;
        res_held = 1'b1;
        tgt0     = t;
        start0   = 1'b1;
        step();
        start0   = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (busy0) seq = {seq[11:0], trial0};
            step();
            if (done0) begin
                ncyc = k;
                break;
            end
            if (result0 !== prev) res_held = 1'b0;
        end
        step();
        done_one = !done0 && !busy0;
    endtask

    // One search on the CMP_LAT=2 instance. TEST slots are the edges that are
    // multiples of three after the start edge; the comparator lies elsewhere.
    task automatic search2(input logic [3:0] t, output logic [15:0] seq,
                           output int ncyc, output bit hold_ok);
        logic [3:0] prev_tr;
        seq     = '0;
        ncyc    = -1;
        hold_ok = 1'b1;
        prev_tr = '0;
        tgt2    = t;
        start2  = 1'b1;
        step();
        start2  = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            garble = (k % 3) != 0;
            if (k > 1 && ((k - 1) % 3) != 0 && trial2 !== prev_tr) hold_ok = 1'b0;
            prev_tr = trial2;
            if ((k % 3) == 0) seq = {seq[11:0], trial2};
            step();
            if (done2) begin
                ncyc = k;
                break;
            end
        end
        garble = 1'b0;
        step();
    endtask

    logic [15:0] seq;
    int          ncyc;
    bit          done_one;
    bit          res_held;
    bit          hold_ok;
    int          ndone;

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        tgt0   = 4'd0;
        tgt2   = 4'd0;
        garble = 1'b0;

        // Reset state
        #1;
        check("rst_trial0",  trial0,  0);
        check("rst_result0", result0, 0);
        check("rst_busy0",   busy0,   0);
        check("rst_done0",   done0,   0);
        check("rst_trial2",  trial2,  0);
        check("rst_result2", result2, 0);
        check("rst_busy2",   busy2,   0);
        check("rst_done2",   done2,   0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Target 9: 8,12,10,9 -> 9, done four edges after start
        search0(4'd9, seq, ncyc, done_one, res_held);
        check("t9_seq",    seq,      16'h8CA9);
        check("t9_cycles", ncyc,     4);
        check("t9_result", result0,  9);
        check("t9_pulse",  done_one, 1);

        // Extremes
        search0(4'd0, seq, ncyc, done_one, res_held);
        check("t0_seq",    seq,     16'h8421);
        check("t0_result", result0, 0);
        check("t0_cycles", ncyc,    4);
        search0(4'd15, seq, ncyc, done_one, res_held);
        check("t15_seq",    seq,     16'h8CEF);
        check("t15_result", result0, 15);
        check("t15_cycles", ncyc,    4);

        // Sweep all targets
        for (int i = 0; i < 16; i++) begin
            search0(4'(i), seq, ncyc, done_one, res_held);
            check($sformatf("sweep_%0d", i), result0, i);
        end

        // CMP_LAT=2, target 5: 8,4,6,5 each held three cycles, done at 12
        search2(4'd5, seq, ncyc, hold_ok);
        check("lat2_seq",    seq,     16'h8465);
        check("lat2_cycles", ncyc,    12);
        check("lat2_result", result2, 5);
        check("lat2_hold",   hold_ok, 1);

        // start pulsed while busy and during DONE, target 7
        ndone  = 0;
        tgt0   = 4'd7;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        ndone += int'(done0);
        step();
        ndone += int'(done0);
        step();
        check("dup_done_edge4", done0, 1);
        ndone += int'(done0);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        check("dup_busy_after", busy0, 0);
        for (int k = 0; k < 6; k++) begin
            ndone += int'(done0);
            step();
        end
        check("dup_done_count", ndone,   1);
        check("dup_result",     result0, 7);

        // Reset in the middle of a search for 11
        tgt0   = 4'd11;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        step();
        step();
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_trial",  trial0,  0);
        check("mid_rst_result", result0, 0);
        check("mid_rst_busy",   busy0,   0);
        check("mid_rst_done",   done0,   0);
        step();
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            ndone += int'(done0);
        end
        check("post_rst_no_done", ndone, 0);
        check("post_rst_idle",    busy0, 0);
        search0(4'd6, seq, ncyc, done_one, res_held);
        check("post_rst_result", result0, 6);

        // Back-to-back: 3 then 12, second start the cycle after done
        search0(4'd3, seq, ncyc, done_one, res_held);
        check("b2b_first", result0, 3);
        search0(4'd12, seq, ncyc, done_one, res_held);
        check("b2b_held",   res_held, 1);
        check("b2b_cycles", ncyc,     4);
        check("b2b_second", result0,  12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
